fetch_stage: RTL



---
 rtl/fetch_stage.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem request, IF/ID register with hold buffer.
// Optional fetch timeout (sticky err, forced halt) is enabled by defining FETCH_TIMEOUT_EN.
module fetch_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_inc,
    output logic        ifid_valid,
    output logic [4:0]  opcode,
    output logic        halted,
    output logic        err
);

    // state   | meaning
    // FETCH   | request issued at pc this cycle
    // WAIT    | request outstanding, waiting for response
    // HOLD    | response captured in hold buffer while stalled
    // DRAIN   | redirected with request in flight, drop next response
    // HALTED  | halt word loaded, no requests until redirect
    typedef enum logic [2:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DRAIN,
        S_HALTED
    } state_t;

    localparam logic [15:0] NOP = 16'h0800;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] hold_q;
    logic [15:0] ifid_instr_q;
    logic [15:0] ifid_pc_inc_q;
    logic        ifid_valid_q;

    logic [15:0] pc_inc_d;
    logic [15:0] load_word_d;
    logic        load_en_d;
    logic        timeout_hit;

    assign pc_inc_d    = pc_q + 16'd2;
    assign load_word_d = (state_q == S_HOLD) ? hold_q : imem_rdata;
    assign load_en_d   = !stall && (((state_q == S_WAIT) && imem_valid) || (state_q == S_HOLD));

`ifdef FETCH_TIMEOUT_EN
    logic [3:0] cnt_q;
    logic       err_q;

    // counts consecutive cycles spent in WAIT/DRAIN; any other state clears it
    always_ff @(posedge clk) begin
        if (rst || !((state_q == S_WAIT) || (state_q == S_DRAIN))) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign timeout_hit = ((state_q == S_WAIT) || (state_q == S_DRAIN)) && (cnt_q == 4'd14)
                         && !redirect && !imem_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FETCH;
            pc_q          <= 16'h0000;
            hold_q        <= 16'h0000;
            ifid_instr_q  <= NOP;
            ifid_pc_inc_q <= 16'h0000;
            ifid_valid_q  <= 1'b0;
        end else if (redirect) begin
            pc_q         <= redirect_pc;
            hold_q       <= 16'h0000;
            ifid_instr_q <= NOP;
            ifid_valid_q <= 1'b0;
            if (((state_q == S_WAIT) && !imem_valid) || (state_q == S_DRAIN)) begin
                state_q <= S_DRAIN;
            end else begin
                state_q <= S_FETCH;
            end
        end else if (load_en_d) begin
            ifid_instr_q  <= load_word_d;
            ifid_pc_inc_q <= pc_inc_d;
            ifid_valid_q  <= 1'b1;
            pc_q          <= pc_inc_d;
            state_q       <= (load_word_d[15:11] == 5'b00000) ? S_HALTED : S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: state_q <= S_WAIT;
                S_WAIT: begin
                    if (imem_valid) begin
                        hold_q  <= imem_rdata;
                        state_q <= S_HOLD;
                    end else if (timeout_hit) begin
                        state_q <= S_HALTED;
                    end
                end
                S_DRAIN: begin
                    if (imem_valid) begin
                        state_q <= S_FETCH;
                    end else if (timeout_hit) begin
                        state_q <= S_HALTED;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign ifid_instr  = ifid_instr_q;
    assign ifid_pc_inc = ifid_pc_inc_q;
    assign ifid_valid  = ifid_valid_q;
    assign opcode      = ifid_instr_q[15:11];
    assign halted      = (state_q == S_HALTED);

endmodule
